// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters into a single fast-to-slow CDC launch channel.
// Launches one payload, waits for the channel busy handshake, then acks the requester or aborts on timeout.
module cdc_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]           cdc_data_o,
  output logic                        cdc_valid_o,
  input  logic                        cdc_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DV_W  = NUM_REQ * DATA_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_data;
  logic [ID_W-1:0]     r_grant;
  logic                r_valid;
  logic                r_busy;
  logic                r_timeout;

  logic [1:0]          w_state_nxt;
  logic [ID_W-1:0]     w_rr_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [NUM_REQ-1:0]  w_ack_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [ID_W-1:0]     w_grant_nxt;
  logic                w_valid_nxt;
  logic                w_timeout_nxt;
  logic [ID_W-1:0]     w_grant_inc;

  logic [NUM_REQ-1:0]  w_rot_req;
  logic [DV_W-1:0]     w_rot_data;
  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  logic [DATA_W-1:0]   w_pick_data;
  logic [SUM_W-1:0]    w_sum;

  // Rotate requests and payloads so index 0 of the rotated view is rr_ptr.
  assign w_rot_req  = NUM_REQ'({req_i, req_i} >> r_rr_ptr);
  assign w_rot_data = DV_W'({data_i, data_i} >> (r_rr_ptr * DATA_W));

  always_comb begin
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_data = '0;
    w_sum       = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_found && w_rot_req[i]) begin
        w_found     = 1'b1;
        w_sum       = {1'b0, r_rr_ptr} + SUM_W'(i);
        if (w_sum >= SUM_W'(NUM_REQ)) begin
          w_sum = w_sum - SUM_W'(NUM_REQ);
        end
        w_pick      = ID_W'(w_sum);
        w_pick_data = w_rot_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_grant_inc = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_nxt      = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    w_ack_nxt     = '0;
    w_data_nxt    = r_data;
    w_grant_nxt   = r_grant;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !cdc_busy_i) begin
          w_grant_nxt = w_pick;
          w_data_nxt  = w_pick_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (cdc_busy_i) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
            w_timeout_nxt = 1'b1;
            w_rr_nxt      = w_grant_inc;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      default: begin
        if (!cdc_busy_i) begin
          w_ack_nxt[r_grant] = 1'b1;
          w_rr_nxt           = w_grant_inc;
          w_state_nxt        = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_data    <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ack     <= w_ack_nxt;
      r_data    <= w_data_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_timeout <= w_timeout_nxt;
    end
  end

  assign ack_o       = r_ack;
  assign cdc_data_o  = r_data;
  assign cdc_valid_o = r_valid;
  assign grant_id_o  = r_grant;
  assign busy_o      = r_busy;
  assign timeout_o   = r_timeout;

endmodule
